// File: rtl/div_pkg.sv
// Shared definitions for the divider issue/writeback controller.
package div_pkg;

    // Controller FSM states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } div_state_t;

    // Default core latency: cycles from core_start to a valid core result.
    localparam int DIV_LAT_DEF = 16;

    // Quotient reported for a zero divisor (all ones).
    localparam logic [31:0] DIV_DBZ_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate: used both to take |x| of signed
// operands and to restore the sign of the unsigned core result.
module div_sign_fix #(
    parameter int DATA_W = 32
) (
    input  logic              neg,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    // Negation wraps modulo 2^DATA_W, so the most negative value maps to itself.
    always_comb begin
        dout = neg ? (DATA_W'(0) - din) : din;
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/writeback controller for the pipelined unsigned divider core.
// Takes one DIV/DIVU at a time, feeds the core absolute operands, waits out
// the fixed core latency, applies the sign fix-up and holds the result for WB.
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_dividend,
    input  logic [DATA_W-1:0] req_divisor,
    output logic [DATA_W-1:0] core_dividend,
    output logic [DATA_W-1:0] core_divisor,
    output logic              core_start,
    input  logic [DATA_W-1:0] core_quotient,
    input  logic [DATA_W-1:0] core_remainder,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_by_zero,
    output logic              stall_req
);

    localparam int CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             neg_q;
    logic             neg_r;

    logic             neg_a_in;
    logic             neg_b_in;
    logic [DATA_W-1:0] abs_a;
    logic [DATA_W-1:0] abs_b;
    logic [DATA_W-1:0] fix_q;
    logic [DATA_W-1:0] fix_r;

    // Operand magnitude is only taken for signed requests with the MSB set.
    always_comb begin
        neg_a_in = req_signed & req_dividend[DATA_W-1];
        neg_b_in = req_signed & req_divisor[DATA_W-1];
    end

    div_sign_fix #(.DATA_W(DATA_W)) u_abs_a (
        .neg  (neg_a_in),
        .din  (req_dividend),
        .dout (abs_a)
    );

    div_sign_fix #(.DATA_W(DATA_W)) u_abs_b (
        .neg  (neg_b_in),
        .din  (req_divisor),
        .dout (abs_b)
    );

    div_sign_fix #(.DATA_W(DATA_W)) u_fix_q (
        .neg  (neg_q),
        .din  (core_quotient),
        .dout (fix_q)
    );

    div_sign_fix #(.DATA_W(DATA_W)) u_fix_r (
        .neg  (neg_r),
        .din  (core_remainder),
        .dout (fix_r)
    );

    assign req_ready = (state == S_IDLE);
    assign stall_req = (state != S_IDLE);

    // Main FSM: accept, start the core, count down its latency, hold result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            core_dividend <= '0;
            core_divisor  <= '0;
            core_start    <= 1'b0;
            resp_valid    <= 1'b0;
            quotient      <= '0;
            remainder     <= '0;
            div_by_zero   <= 1'b0;
        end else if (flush) begin
            // Abort: any result still travelling through the core is dropped
            // because the countdown that would capture it is gone.
            state       <= S_IDLE;
            cnt         <= '0;
            core_start  <= 1'b0;
            resp_valid  <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    core_start <= 1'b0;
                    if (req_valid) begin
                        neg_q         <= req_signed & (req_dividend[DATA_W-1] ^ req_divisor[DATA_W-1]);
                        neg_r         <= req_signed & req_dividend[DATA_W-1];
                        core_dividend <= abs_a;
                        core_divisor  <= abs_b;
                        if (req_divisor == '0) begin
                            // Zero divisor resolves locally without the core.
                            quotient    <= DATA_W'(DIV_DBZ_QUOT);
                            remainder   <= req_dividend;
                            div_by_zero <= 1'b1;
                            resp_valid  <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            div_by_zero <= 1'b0;
                            core_start  <= 1'b1;
                            state       <= S_START;
                        end
                    end
                end
                S_START: begin
                    core_start <= 1'b0;
                    cnt        <= CNT_W'(DIV_LAT - 1);
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        quotient   <= fix_q;
                        remainder  <= fix_r;
                        resp_valid <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a fixed-latency behavioural core.
module tb_div_issue_ctrl;

    localparam int DATA_W  = 32;
    localparam int DIV_LAT = 16;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              req_valid;
    logic              req_ready;
    logic              req_signed;
    logic [DATA_W-1:0] req_dividend;
    logic [DATA_W-1:0] req_divisor;
    logic [DATA_W-1:0] core_dividend;
    logic [DATA_W-1:0] core_divisor;
    logic              core_start;
    logic [DATA_W-1:0] core_quotient;
    logic [DATA_W-1:0] core_remainder;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] remainder;
    logic              div_by_zero;
    logic              stall_req;

    int total = 0;
    int bad   = 0;

    div_issue_ctrl #(.DATA_W(DATA_W), .DIV_LAT(DIV_LAT)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_signed     (req_signed),
        .req_dividend   (req_dividend),
        .req_divisor    (req_divisor),
        .core_dividend  (core_dividend),
        .core_divisor   (core_divisor),
        .core_start     (core_start),
        .core_quotient  (core_quotient),
        .core_remainder (core_remainder),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .quotient       (quotient),
        .remainder      (remainder),
        .div_by_zero    (div_by_zero),
        .stall_req      (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural core: result of the operands seen with core_start appears
    // exactly DIV_LAT cycles later; other slots carry junk.
    logic [63:0] core_pipe [DIV_LAT];
    always @(posedge clk) begin
        for (int i = DIV_LAT - 1; i > 0; i--) core_pipe[i] <= core_pipe[i-1];
        if (core_start)
            core_pipe[0] <= (core_divisor != 0) ?
                {core_dividend / core_divisor, core_dividend % core_divisor} :
                {32'hFFFF_FFFF, core_dividend};
        else
            core_pipe[0] <= 64'hDEAD_BEEF_BAD0_BAD0;
    end
    assign core_quotient  = core_pipe[DIV_LAT-1][63:32];
    assign core_remainder = core_pipe[DIV_LAT-1][31:0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request, then wait (bounded) for resp_valid. lat counts
    // edges from the accept edge inclusive; starts counts core_start cycles.
    task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int starts);
        req_valid    = 1'b1;
        req_signed   = sg;
        req_dividend = a;
        req_divisor  = b;
        starts = 0;
        tick();
        req_valid = 1'b0;
        lat = 1;
        if (core_start) starts++;
        while (!resp_valid && lat < 40) begin
            tick();
            lat++;
            if (core_start) starts++;
        end
    endtask

    int lat, starts;
    logic ok;
    logic [31:0] q_hold, r_hold;

    initial begin
        reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_signed = 1'b0;
        req_dividend = '0; req_divisor = '0; resp_ready = 1'b1;

        // Reset state
        tick(); tick(); tick();
        reset = 1'b0;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_core_start", 32'(core_start), 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        chk("rst_core_dividend", core_dividend, 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        tick();

        // 1. DIVU 7/2
        run_op(1'b0, 32'd7, 32'd2, lat, starts);
        chk("t1_latency", 32'(lat), 32'd18);
        chk("t1_starts", 32'(starts), 32'd1);
        chk("t1_q", quotient, 32'd3);
        chk("t1_r", remainder, 32'd1);
        chk("t1_dbz", 32'(div_by_zero), 32'd0);
        chk("t1_stall", 32'(stall_req), 32'd1);
        tick();
        chk("t1_idle_ready", 32'(req_ready), 32'd1);
        chk("t1_resp_clr", 32'(resp_valid), 32'd0);

        // 2. Signed divides
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, starts);
        chk("t2a_q", quotient, 32'hFFFF_FFFD);
        chk("t2a_r", remainder, 32'hFFFF_FFFF);
        chk("t2a_abs_a", core_dividend, 32'd7);
        chk("t2a_latency", 32'(lat), 32'd18);
        tick();
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, lat, starts);
        chk("t2b_q", quotient, 32'hFFFF_FFFD);
        chk("t2b_r", remainder, 32'd1);
        chk("t2b_abs_b", core_divisor, 32'd2);
        tick();
        run_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, lat, starts);
        chk("t2c_q", quotient, 32'd3);
        chk("t2c_r", remainder, 32'hFFFF_FFFF);
        tick();

        // 3. Most negative / -1, signed and unsigned
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, starts);
        chk("t3s_q", quotient, 32'h8000_0000);
        chk("t3s_r", remainder, 32'd0);
        tick();
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, starts);
        chk("t3u_q", quotient, 32'd0);
        chk("t3u_r", remainder, 32'h8000_0000);
        tick();

        // 4. Divide by zero
        run_op(1'b0, 32'd5, 32'd0, lat, starts);
        chk("t4_latency", 32'(lat), 32'd1);
        chk("t4_starts", 32'(starts), 32'd0);
        chk("t4_q", quotient, 32'hFFFF_FFFF);
        chk("t4_r", remainder, 32'd5);
        chk("t4_dbz", 32'(div_by_zero), 32'd1);
        tick();
        chk("t4_no_start_after", 32'(core_start), 32'd0);
        chk("t4_idle_ready", 32'(req_ready), 32'd1);

        // 5. Backpressure in DONE: DIVU 100/7
        resp_ready = 1'b0;
        run_op(1'b0, 32'd100, 32'd7, lat, starts);
        chk("t5_q", quotient, 32'd14);
        chk("t5_r", remainder, 32'd2);
        q_hold = quotient;
        r_hold = remainder;
        for (int i = 0; i < 10; i++) begin
            tick();
            ok = resp_valid && stall_req && !req_ready && quotient == q_hold && remainder == r_hold;
            chk("t5_hold", 32'(ok), 32'd1);
        end
        resp_ready = 1'b1;
        tick();
        chk("t5_release_ready", 32'(req_ready), 32'd1);
        chk("t5_release_resp", 32'(resp_valid), 32'd0);

        // 6. Flush in WAIT (cnt=5) with a request also presented
        req_valid = 1'b1; req_signed = 1'b0; req_dividend = 32'd50; req_divisor = 32'd3;
        tick();
        req_valid = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (resp_valid || req_ready) ok = 1'b0;
        end
        chk("t6_busy_before_flush", 32'(ok), 32'd1);
        flush = 1'b1;
        req_valid = 1'b1; req_dividend = 32'd9; req_divisor = 32'd4;
        tick();
        flush = 1'b0;
        req_valid = 1'b0;
        chk("t6_flush_idle", 32'(req_ready), 32'd1);
        chk("t6_flush_resp", 32'(resp_valid), 32'd0);
        chk("t6_flush_stall", 32'(stall_req), 32'd0);
        chk("t6_flush_start", 32'(core_start), 32'd0);
        run_op(1'b0, 32'd1000, 32'd7, lat, starts);
        chk("t6_new_latency", 32'(lat), 32'd18);
        chk("t6_new_q", quotient, 32'd142);
        chk("t6_new_r", remainder, 32'd6);
        chk("t6_new_dbz", 32'(div_by_zero), 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
